// File: rtl/cavlc_level_vlc_encoder_pkg.sv
// Shared constants and FSM encoding for the CAVLC level codeword serialiser.
// Prefix/suffix split thresholds follow the H.264 level_prefix escape rules.
package cavlc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_PREFIX = 3'd2,
    S_STOP   = 3'd3,
    S_SUFFIX = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] ESC_PREFIX     = 4'd15;
  localparam logic [3:0] PREFIX14       = 4'd14;
  localparam logic [3:0] PREFIX14_SSIZE = 4'd4;
  localparam logic [3:0] ESC_SSIZE      = 4'd12;
  localparam int         SL0_ESC_BASE   = 30;
  localparam int         SL0_P14_BASE   = 14;

endpackage

// File: rtl/cavlc_level_vlc_encoder_level_code_split.sv
// Combinational split of (levelCode, suffixLength) into level_prefix, level_suffix and suffix size.
// Arithmetic is widened by 4 bits so the escape threshold and subtraction never wrap.
module level_code_split
  import cavlc_pkg::*;
#(
  parameter int DATA_WIDTH  = 9,
  parameter int SUFFIX_MAXW = 12
) (
  input  logic [DATA_WIDTH:0]      c,
  input  logic [2:0]               sl,
  output logic [3:0]               prefix,
  output logic [SUFFIX_MAXW-1:0]   suffix,
  output logic [3:0]               ssize,
  output logic                     overflow
);
  localparam int XW = DATA_WIDTH + 5;

  logic [XW-1:0] c_ext;
  logic [XW-1:0] thr;
  logic [XW-1:0] mask;
  logic [XW-1:0] diff;
  logic [XW-1:0] shifted;
  logic [XW-1:0] low;

  assign c_ext   = XW'(c);
  assign thr     = XW'(15) << sl;
  assign mask    = (XW'(1) << sl) - XW'(1);
  assign shifted = c_ext >> sl;
  assign low     = c_ext & mask;

  always_comb begin
    prefix   = '0;
    suffix   = '0;
    ssize    = '0;
    diff     = '0;
    overflow = 1'b0;
    if (sl == 3'd0) begin
      if (c_ext < XW'(SL0_P14_BASE)) begin
        prefix = c_ext[3:0];
      end else if (c_ext < XW'(SL0_ESC_BASE)) begin
        prefix = PREFIX14;
        diff   = c_ext - XW'(SL0_P14_BASE);
        ssize  = PREFIX14_SSIZE;
      end else begin
        prefix = ESC_PREFIX;
        diff   = c_ext - XW'(SL0_ESC_BASE);
        ssize  = ESC_SSIZE;
      end
    end else if (c_ext < thr) begin
      prefix = shifted[3:0];
      diff   = low;
      ssize  = {1'b0, sl};
    end else begin
      prefix = ESC_PREFIX;
      diff   = c_ext - thr;
      ssize  = ESC_SSIZE;
    end
    // Only the escape form can exceed the suffix field; low bits are still emitted.
    overflow = (prefix == ESC_PREFIX) && (diff >= (XW'(1) << SUFFIX_MAXW));
    suffix   = diff[SUFFIX_MAXW-1:0];
  end

endmodule

// File: rtl/cavlc_level_vlc_encoder.sv
// Serialises one H.264 level codeword (prefix zeros, stop '1', suffix MSB-first) per start pulse
// over a valid/ready bit stream; finish pulses one cycle after the last accepted bit.
module cavlc_level_vlc_encoder
  import cavlc_pkg::*;
#(
  parameter int DATA_WIDTH  = 9,
  parameter int SUFFIX_MAXW = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH:0]   level_code,
  input  logic [2:0]            suffix_len,
  output logic                  busy,
  output logic                  bit_out,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic                  finish,
  output logic [3:0]            prefix_len,
  output logic [4:0]            cw_len,
  output logic                  overflow
);
  state_t state, state_nxt;

  logic [DATA_WIDTH:0]      c_q;
  logic [2:0]               sl_q;
  logic [SUFFIX_MAXW-1:0]   suffix_q;
  logic [3:0]               ssize_q;
  logic [3:0]               cnt;
  logic [3:0]               idx;
  logic                     accept;

  logic [3:0]               sp_prefix;
  logic [SUFFIX_MAXW-1:0]   sp_suffix;
  logic [3:0]               sp_ssize;
  logic                     sp_ovf;

  level_code_split #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SUFFIX_MAXW (SUFFIX_MAXW)
  ) u_split (
    .c        (c_q),
    .sl       (sl_q),
    .prefix   (sp_prefix),
    .suffix   (sp_suffix),
    .ssize    (sp_ssize),
    .overflow (sp_ovf)
  );

  assign accept = bit_valid && bit_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CALC;
      end
      S_CALC: state_nxt = (sp_prefix == 4'd0) ? S_STOP : S_PREFIX;
      S_PREFIX: begin
        bit_valid = 1'b1;
        if (bit_ready && cnt == 4'd1) state_nxt = S_STOP;
      end
      S_STOP: begin
        bit_valid = 1'b1;
        bit_out   = 1'b1;
        if (bit_ready) state_nxt = (ssize_q != 4'd0) ? S_SUFFIX : S_DONE;
      end
      S_SUFFIX: begin
        bit_valid = 1'b1;
        bit_out   = suffix_q[idx];
        if (bit_ready && idx == 4'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q        <= '0;
      sl_q       <= '0;
      suffix_q   <= '0;
      ssize_q    <= '0;
      cnt        <= '0;
      idx        <= '0;
      prefix_len <= '0;
      cw_len     <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            c_q  <= level_code;
            sl_q <= suffix_len;
          end
        end
        S_CALC: begin
          prefix_len <= sp_prefix;
          suffix_q   <= sp_suffix;
          ssize_q    <= sp_ssize;
          cnt        <= sp_prefix;
          cw_len     <= 5'(sp_prefix) + 5'd1 + 5'(sp_ssize);
          if (sp_ovf) overflow <= 1'b1;
        end
        S_PREFIX: if (accept) cnt <= cnt - 4'd1;
        S_STOP:   if (accept) idx <= ssize_q - 4'd1;
        S_SUFFIX: if (accept && idx != 4'd0) idx <= idx - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_level_vlc_encoder.sv
// Directed table-driven bench for the CAVLC level codeword serialiser, plus back-pressure,
// dropped-start and mid-codeword reset sequences.
module tb_cavlc_level_vlc_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  level_code;
  logic [2:0]  suffix_len;
  logic        busy;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        finish;
  logic [3:0]  prefix_len;
  logic [4:0]  cw_len;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cavlc_level_vlc_encoder #(.DATA_WIDTH(9), .SUFFIX_MAXW(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .level_code (level_code),
    .suffix_len (suffix_len),
    .busy       (busy),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .finish     (finish),
    .prefix_len (prefix_len),
    .cw_len     (cw_len),
    .overflow   (overflow)
  );

  typedef struct {
    logic [2:0]  sl;
    logic [9:0]  c;
    int          prefix;
    int          cw;
    logic [27:0] code;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Runs one codeword, collecting accepted bits; toggle drives bit_ready 1/0, poke pulses start mid-stream.
  task automatic run_cw(input vec_t v, input bit toggle, input bit poke);
    logic [27:0] got = '0;
    int nbits = 0, k = 1, first_v = -1, last_acc = -1, fin_k = -1;
    bit pend = 0, held_b = 0, hold_ok = 1;
    @(negedge clk);
    suffix_len = v.sl; level_code = v.c; start = 1'b1; bit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; level_code = ~v.c; suffix_len = 3'd7;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("no_valid_in_calc", {31'd0, bit_valid}, 32'd0);
    while (fin_k < 0 && k < 200) begin
      @(negedge clk);
      k++;
      bit_ready = toggle ? k[0] : 1'b1;
      start     = (poke && (k == 6 || k == 12)) ? 1'b1 : 1'b0;
      if (pend && !(bit_valid && bit_out == held_b)) hold_ok = 0;
      if (bit_valid && first_v < 0) first_v = k;
      if (bit_valid && bit_ready) begin
        got = {got[26:0], bit_out};
        nbits++;
        last_acc = k;
      end
      pend = bit_valid && !bit_ready;
      held_b = bit_out;
      if (finish) begin
        fin_k = k;
        chk("prefix_len", {28'd0, prefix_len}, v.prefix);
        chk("cw_len", {27'd0, cw_len}, v.cw);
        chk("valid_low_at_finish", {31'd0, bit_valid}, 32'd0);
      end
    end
    start = 1'b0;
    chk("finish_seen", {31'd0, fin_k >= 0}, 32'd1);
    chk("first_valid_cycle", first_v, 32'd2);
    chk("bit_count", nbits, v.cw);
    chk("bit_pattern", {4'd0, got}, {4'd0, v.code});
    chk("held_while_stalled", {31'd0, hold_ok}, 32'd1);
    chk("finish_after_last_accept", fin_k, last_acc + 1);
    if (!toggle) chk("finish_latency", fin_k, 2 + v.cw);
    @(negedge clk);
    chk("finish_single_pulse", {31'd0, finish}, 32'd0);
    chk("busy_cleared", {31'd0, busy}, 32'd0);
    chk("overflow_clear", {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 10'd3,    3,  4, 28'b0001};
    vecs[1]  = '{3'd0, 10'd20,  14, 19, 28'b1_0110};
    vecs[2]  = '{3'd0, 10'd40,  15, 28, 28'b1_000000001010};
    vecs[3]  = '{3'd2, 10'd13,   3,  6, 28'b1_01};
    vecs[4]  = '{3'd1, 10'd35,  15, 28, 28'b1_000000000101};
    vecs[5]  = '{3'd0, 10'd0,    0,  1, 28'b1};
    vecs[6]  = '{3'd0, 10'd13,  13, 14, 28'b1};
    vecs[7]  = '{3'd0, 10'd14,  14, 19, 28'b1_0000};
    vecs[8]  = '{3'd0, 10'd29,  14, 19, 28'b1_1111};
    vecs[9]  = '{3'd0, 10'd30,  15, 28, 28'b1_000000000000};
    vecs[10] = '{3'd3, 10'd100, 12, 16, 28'b1_100};
    vecs[11] = '{3'd6, 10'd1023,15, 28, 28'b1_000000111111};

    rst = 1'b1; start = 1'b0; level_code = '0; suffix_len = '0; bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, bit_valid}, 32'd0);
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_cw_len", {27'd0, cw_len}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);

    for (int i = 0; i < 12; i++) run_cw(vecs[i], 1'b0, 1'b0);

    // Back-pressure on the 19-bit codeword with stray start pulses mid-stream.
    run_cw(vecs[1], 1'b1, 1'b1);

    // Reset while the 5th bit of the 28-bit escape codeword is on the bus.
    @(negedge clk);
    suffix_len = 3'd0; level_code = 10'd40; start = 1'b1; bit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_valid", {31'd0, bit_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, bit_valid}, 32'd0);
    chk("abort_bit", {31'd0, bit_out}, 32'd0);
    chk("abort_prefix_len", {28'd0, prefix_len}, 32'd0);
    chk("abort_cw_len", {27'd0, cw_len}, 32'd0);
    begin
      bit fin_seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (finish || busy) fin_seen = 1;
      end
      chk("no_finish_after_abort", {31'd0, fin_seen}, 32'd0);
    end
    run_cw(vecs[5], 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
